i2c_slave_frame_cnt: RTL and testbench
======================================

// Module: i2c_slave_frame_cnt
// PURPOSE
//  Parametrised bit/byte frame tracker for the I2C slave datapath. Counts sampled SCL rising
//  edges inside a transfer, flags end of each data byte and the ACK slot, and counts bytes
//  since the last (repeated) START. Sits between the START/STOP detector and the shift-register
//  and FSM logic of i2c_slave; replaces the fixed 8-bit equal-compare counter.
// PARAMETERS
//  DATA_BITS    8      data bits per byte before the ACK slot (legal 1..15)
//  BYTE_CNT_W   8      width of byte counter
//  BYTE_SAT     1      1: byte_cnt saturates at all-ones; 0: wraps to 0
//  TIMEOUT_CYC  1024   pclk cycles without scl_rise before timeout (used only with macro)
// PORTS
//  pclk         in   1               system clock
//  preset       in   1               synchronous reset, active-high
//  start_det    in   1               1-cycle pulse: START or repeated START seen
//  stop_det     in   1               1-cycle pulse: STOP seen
//  scl_rise     in   1               1-cycle pulse: synchronised SCL rising edge
//  bit_idx      out  BIT_W           bits received in current byte, BIT_W=$clog2(DATA_BITS+1)
//  byte_done    out  1               1-cycle pulse: DATA_BITS-th bit sampled
//  ack_slot     out  1               level: ACK/NACK bit window active
//  ack_done     out  1               1-cycle pulse: ACK bit sampled
//  byte_cnt     out  BYTE_CNT_W      completed bytes (data+ACK) since last START
//  first_byte   out  1               high in DATA/ACK while byte_cnt==0 (address byte)
//  busy         out  1               state != IDLE
//  timeout      out  1               1-cycle pulse on bus timeout (0 when macro absent)
// BEHAVIOUR
//  Interface: one clock, pclk; reset preset is synchronous and active-high.
//  Reset: state IDLE, bit_idx=0, byte_cnt=0, all pulses 0, ack_slot=0, busy=0.
//  States (frame_state_t): IDLE, DATA, ACK. All outputs registered; pulses 1 cycle after event.
//  Event priority per cycle: preset > stop_det > start_det > timeout > scl_rise.
//  IDLE: scl_rise ignored. start_det -> DATA, bit_idx=0, byte_cnt=0.
//  DATA: scl_rise -> bit_idx+1. On scl_rise with bit_idx==DATA_BITS-1: bit_idx=DATA_BITS,
//   byte_done=1 next cycle, -> ACK.
//  ACK: ack_slot=1. scl_rise -> ack_done=1, bit_idx=0, byte_cnt+1 (BYTE_SAT rule), -> DATA.
//  stop_det in any state -> IDLE, bit_idx=0; byte_cnt holds until next START.
//  start_det in DATA/ACK (repeated START, mid-byte legal) -> DATA, bit_idx=0, byte_cnt=0,
//   no byte_done/ack_done for the aborted byte.
//  start_det and stop_det same cycle -> IDLE (stop wins).
//  byte_cnt at all-ones + ack_done: BYTE_SAT=1 holds all-ones; BYTE_SAT=0 -> 0.
//  bit_idx never exceeds DATA_BITS.
// CONFIGURATION
//  I2C_SLAVE_FRAME_TIMEOUT_EN defined: cycle counter clears on scl_rise/start_det/entry to
//   DATA, increments while busy; reaching TIMEOUT_CYC-1 -> timeout=1 next cycle, -> IDLE,
//   bit_idx=0. Counter held at 0 in IDLE.
//  Macro undefined: no timeout counter; timeout tied 0; TIMEOUT_CYC unused.
// STRUCTURE
//  i2c_slave_pkg: frame_state_t enum {IDLE,DATA,ACK}, default DATA_BITS/BYTE_CNT_W constants.
//  Sub-module i2c_slave_up_cnt (parametrised width, en, clr, sat-select) instantiated for
//   bit counter, byte counter and (macro) timeout counter. FSM and pulse regs in top.
// TESTING
//  Reset then START + 9 scl_rise -> byte_done 1 cycle after 8th, ack_slot high, ack_done
//   after 9th, byte_cnt=1, first_byte falls.
//  START, 4 scl_rise, repeated START, 9 scl_rise -> no byte_done for partial, byte_cnt=1.
//  START+STOP same cycle in DATA -> IDLE, busy=0; following scl_rise ignored.
//  BYTE_CNT_W=2: 5 full bytes -> BYTE_SAT=1 byte_cnt=3; BYTE_SAT=0 byte_cnt=1.
//  DATA_BITS=4: 5 scl_rise -> byte_done after 4th, ack_done after 5th.
//  Macro on, TIMEOUT_CYC=16: START, 3 scl_rise, idle 16 cycles -> timeout pulse, IDLE, bit_idx=0.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared types and default sizes for the I2C slave frame tracking logic.
package i2c_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ACK  = 2'd2
  } frame_state_t;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_BYTE_CNT_W = 8;

endpackage

// File: rtl/i2c_slave_up_cnt.sv
// Generic up-counter with synchronous clear (wins over enable) and
// selectable saturate-at-all-ones or wrap-to-zero behaviour.
module i2c_slave_up_cnt import i2c_slave_pkg::*; #(
  parameter int W = DEF_BYTE_CNT_W
) (
  input  logic         pclk,
  input  logic         preset,
  input  logic         clr,
  input  logic         en,
  input  logic         sat,
  output logic [W-1:0] q
);

  logic [W-1:0] q_nxt;

  always_comb begin
    q_nxt = q;
    if (clr) begin
      q_nxt = '0;
    end else if (en) begin
      if (&q) q_nxt = sat ? q : '0;
      else    q_nxt = q + W'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) q <= '0;
    else        q <= q_nxt;
  end

endmodule

// File: rtl/i2c_slave_frame_cnt.sv
// Bit/byte frame tracker for the I2C slave: bit index, byte/ACK pulses, byte count.
// Optional bus timeout is built when I2C_SLAVE_FRAME_TIMEOUT_EN is defined.
//
//   state | meaning
//   IDLE  | no transfer; scl_rise ignored
//   DATA  | shifting data bits, bit_idx counts sampled bits
//   ACK   | all data bits in, waiting for the ACK/NACK clock
module i2c_slave_frame_cnt import i2c_slave_pkg::*; #(
  parameter  int DATA_BITS   = DEF_DATA_BITS,
  parameter  int BYTE_CNT_W  = DEF_BYTE_CNT_W,
  parameter  int BYTE_SAT    = 1,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int BIT_W       = $clog2(DATA_BITS + 1)
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  start_det,
  input  logic                  stop_det,
  input  logic                  scl_rise,
  output logic [BIT_W-1:0]      bit_idx,
  output logic                  byte_done,
  output logic                  ack_slot,
  output logic                  ack_done,
  output logic [BYTE_CNT_W-1:0] byte_cnt,
  output logic                  first_byte,
  output logic                  busy,
  output logic                  timeout
);

  frame_state_t state, state_nxt;

  logic start_evt, tmo_evt, rise_evt;
  logic data_rise, ack_rise, last_bit;
  logic byte_wraps;

  // Priority: stop > start > timeout > scl_rise
  assign start_evt = start_det & ~stop_det;
  assign rise_evt  = scl_rise & ~stop_det & ~start_det & ~tmo_evt;
  assign data_rise = rise_evt & (state == DATA);
  assign ack_rise  = rise_evt & (state == ACK);
  assign last_bit  = data_rise & (bit_idx == BIT_W'(DATA_BITS - 1));
  assign byte_wraps = (BYTE_SAT == 0) & (&byte_cnt);

`ifdef I2C_SLAVE_FRAME_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMO_W-1:0] tmo_q;
  logic             tmo_clr;

  assign tmo_clr = (state == IDLE) | scl_rise | start_det | stop_det | tmo_evt;
  assign tmo_evt = (state != IDLE) & ~stop_det & ~start_det &
                   (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  i2c_slave_up_cnt #(.W(TMO_W)) u_tmo_cnt (
    .pclk   (pclk),
    .preset (preset),
    .clr    (tmo_clr),
    .en     (state != IDLE),
    .sat    (1'b1),
    .q      (tmo_q)
  );
`else
  assign tmo_evt = 1'b0;
`endif

  i2c_slave_up_cnt #(.W(BIT_W)) u_bit_cnt (
    .pclk   (pclk),
    .preset (preset),
    .clr    (stop_det | start_det | tmo_evt | ack_rise),
    .en     (data_rise),
    .sat    (1'b1),
    .q      (bit_idx)
  );

  i2c_slave_up_cnt #(.W(BYTE_CNT_W)) u_byte_cnt (
    .pclk   (pclk),
    .preset (preset),
    .clr    (start_evt),
    .en     (ack_rise),
    .sat    (BYTE_SAT != 0),
    .q      (byte_cnt)
  );

  always_comb begin
    state_nxt = state;
    if (stop_det)       state_nxt = IDLE;
    else if (start_det) state_nxt = DATA;
    else if (tmo_evt)   state_nxt = IDLE;
    else if (last_bit)  state_nxt = ACK;
    else if (ack_rise)  state_nxt = DATA;
  end

  // Level outputs are registered from next-state so they line up with the counters
  always_ff @(posedge pclk) begin
    if (preset) begin
      state      <= IDLE;
      byte_done  <= 1'b0;
      ack_done   <= 1'b0;
      ack_slot   <= 1'b0;
      busy       <= 1'b0;
      first_byte <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      byte_done  <= last_bit;
      ack_done   <= ack_rise;
      ack_slot   <= (state_nxt == ACK);
      busy       <= (state_nxt != IDLE);
      first_byte <= (state_nxt != IDLE) &
                    (start_evt | ((byte_cnt == '0) & ~ack_rise) | (ack_rise & byte_wraps));
`ifdef I2C_SLAVE_FRAME_TIMEOUT_EN
      timeout    <= tmo_evt;
`else
      timeout    <= 1'b0 & (TIMEOUT_CYC > 0);
`endif
    end
  end

endmodule

// File: tb/tb_i2c_slave_frame_cnt.sv
// Self-checking bench: four parameterisations share one stimulus stream and are
// compared every cycle against a frame-level model, plus literal spot checks.
module tb_i2c_slave_frame_cnt;

  logic pclk = 1'b0;
  logic preset = 1'b1, start_det = 1'b0, stop_det = 1'b0, scl_rise = 1'b0;
  always #5 pclk = ~pclk;

`ifdef I2C_SLAVE_FRAME_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  localparam int TCYC = 16;

  logic [3:0] bi0, bi1, bi2;
  logic [2:0] bi3;
  logic [7:0] bc0, bc3;
  logic [1:0] bc1, bc2;
  logic bd_o[4], as_o[4], ad_o[4], fb_o[4], bz_o[4], to_o[4];

  i2c_slave_frame_cnt #(.DATA_BITS(8), .BYTE_CNT_W(8), .BYTE_SAT(1), .TIMEOUT_CYC(TCYC)) u0 (
    .pclk(pclk), .preset(preset), .start_det(start_det), .stop_det(stop_det), .scl_rise(scl_rise),
    .bit_idx(bi0), .byte_done(bd_o[0]), .ack_slot(as_o[0]), .ack_done(ad_o[0]), .byte_cnt(bc0),
    .first_byte(fb_o[0]), .busy(bz_o[0]), .timeout(to_o[0]));
  i2c_slave_frame_cnt #(.DATA_BITS(8), .BYTE_CNT_W(2), .BYTE_SAT(1), .TIMEOUT_CYC(TCYC)) u1 (
    .pclk(pclk), .preset(preset), .start_det(start_det), .stop_det(stop_det), .scl_rise(scl_rise),
    .bit_idx(bi1), .byte_done(bd_o[1]), .ack_slot(as_o[1]), .ack_done(ad_o[1]), .byte_cnt(bc1),
    .first_byte(fb_o[1]), .busy(bz_o[1]), .timeout(to_o[1]));
  i2c_slave_frame_cnt #(.DATA_BITS(8), .BYTE_CNT_W(2), .BYTE_SAT(0), .TIMEOUT_CYC(TCYC)) u2 (
    .pclk(pclk), .preset(preset), .start_det(start_det), .stop_det(stop_det), .scl_rise(scl_rise),
    .bit_idx(bi2), .byte_done(bd_o[2]), .ack_slot(as_o[2]), .ack_done(ad_o[2]), .byte_cnt(bc2),
    .first_byte(fb_o[2]), .busy(bz_o[2]), .timeout(to_o[2]));
  i2c_slave_frame_cnt #(.DATA_BITS(4), .BYTE_CNT_W(8), .BYTE_SAT(1), .TIMEOUT_CYC(TCYC)) u3 (
    .pclk(pclk), .preset(preset), .start_det(start_det), .stop_det(stop_det), .scl_rise(scl_rise),
    .bit_idx(bi3), .byte_done(bd_o[3]), .ack_slot(as_o[3]), .ack_done(ad_o[3]), .byte_cnt(bc3),
    .first_byte(fb_o[3]), .busy(bz_o[3]), .timeout(to_o[3]));

  int o_bit[4], o_cnt[4];
  always_comb begin
    o_bit[0] = int'(bi0); o_bit[1] = int'(bi1); o_bit[2] = int'(bi2); o_bit[3] = int'(bi3);
    o_cnt[0] = int'(bc0); o_cnt[1] = int'(bc1); o_cnt[2] = int'(bc2); o_cnt[3] = int'(bc3);
  end

  function automatic int db_of(int k);  return (k == 3) ? 4 : 8; endfunction
  function automatic int max_of(int k); return (k == 1 || k == 2) ? 3 : 255; endfunction
  function automatic bit sat_of(int k); return (k != 2); endfunction

  int n_chk = 0, n_err = 0;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: in-frame flag, bits taken, bytes completed, idle cycles
  bit m_fr[4], m_bd[4], m_ad[4], m_to[4];
  int m_bits[4], m_bytes[4], m_idle[4];

  always @(posedge pclk) begin
    for (int k = 0; k < 4; k++) begin
      m_bd[k] = 0; m_ad[k] = 0; m_to[k] = 0;
      if (preset) begin
        m_fr[k] = 0; m_bits[k] = 0; m_bytes[k] = 0; m_idle[k] = 0;
      end else begin
        if (stop_det) begin
          m_fr[k] = 0; m_bits[k] = 0;
        end else if (start_det) begin
          m_fr[k] = 1; m_bits[k] = 0; m_bytes[k] = 0;
        end else if (TMO_ON && m_fr[k] && m_idle[k] == TCYC - 1) begin
          m_to[k] = 1; m_fr[k] = 0; m_bits[k] = 0;
        end else if (scl_rise && m_fr[k]) begin
          if (m_bits[k] < db_of(k)) begin
            m_bits[k]++;
            if (m_bits[k] == db_of(k)) m_bd[k] = 1;
          end else begin
            m_ad[k] = 1;
            m_bits[k] = 0;
            if (m_bytes[k] == max_of(k)) m_bytes[k] = sat_of(k) ? max_of(k) : 0;
            else m_bytes[k]++;
          end
        end
        m_idle[k] = (!m_fr[k] || scl_rise || start_det) ? 0 : m_idle[k] + 1;
      end
    end
  end

  bit chk_en = 0;
  int bd_cnt[4];
  always @(negedge pclk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("u%0d.bit_idx", k),    o_bit[k],      m_bits[k]);
        check($sformatf("u%0d.byte_cnt", k),   o_cnt[k],      m_bytes[k]);
        check($sformatf("u%0d.byte_done", k),  int'(bd_o[k]), int'(m_bd[k]));
        check($sformatf("u%0d.ack_done", k),   int'(ad_o[k]), int'(m_ad[k]));
        check($sformatf("u%0d.ack_slot", k),   int'(as_o[k]), int'(m_fr[k] && m_bits[k] == db_of(k)));
        check($sformatf("u%0d.first_byte", k), int'(fb_o[k]), int'(m_fr[k] && m_bytes[k] == 0));
        check($sformatf("u%0d.busy", k),       int'(bz_o[k]), int'(m_fr[k]));
        check($sformatf("u%0d.timeout", k),    int'(to_o[k]), int'(m_to[k]));
        if (bd_o[k]) bd_cnt[k]++;
      end
    end
  end

  task automatic step(input bit st, input bit sp, input bit r);
    start_det = st; stop_det = sp; scl_rise = r;
    @(posedge pclk); #1;
    start_det = 0; stop_det = 0; scl_rise = 0;
  endtask

  task automatic rises(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 1);
      if (gap && i < n - 1) step(0, 0, 0);
    end
  endtask

  int bd_before;

  initial begin
    for (int k = 0; k < 4; k++) bd_cnt[k] = 0;
    repeat (2) @(posedge pclk);
    #1;
    chk_en = 1;
    preset = 0;
    check("reset.busy", int'(bz_o[0]), 0);
    check("reset.bit_idx", o_bit[0], 0);
    check("reset.byte_cnt", o_cnt[0], 0);
    check("reset.ack_slot", int'(as_o[0]), 0);

    // single full byte
    step(1, 0, 0);
    check("start.busy", int'(bz_o[0]), 1);
    check("start.first_byte", int'(fb_o[0]), 1);
    rises(8, 1);
    check("b8.byte_done", int'(bd_o[0]), 1);
    check("b8.ack_slot", int'(as_o[0]), 1);
    check("b8.bit_idx", o_bit[0], 8);
    step(0, 0, 0);
    check("b8.byte_done_clears", int'(bd_o[0]), 0);
    step(0, 0, 1);
    check("b9.ack_done", int'(ad_o[0]), 1);
    check("b9.byte_cnt", o_cnt[0], 1);
    check("b9.first_byte", int'(fb_o[0]), 0);
    check("b9.ack_slot", int'(as_o[0]), 0);
    check("d4.bit_idx_after9", o_bit[3], 4);
    check("d4.ack_slot_after9", int'(as_o[3]), 1);

    // partial byte aborted by repeated START
    step(0, 1, 0);
    step(1, 0, 0);
    rises(4, 0);
    bd_before = bd_cnt[0];
    step(1, 0, 0);
    check("rs.bit_idx", o_bit[0], 0);
    check("rs.byte_cnt", o_cnt[0], 0);
    rises(9, 0);
    step(0, 0, 0);
    check("rs.byte_cnt_after", o_cnt[0], 1);
    check("rs.byte_done_count", bd_cnt[0] - bd_before, 1);

    // START and STOP together: stop wins, later clocks ignored
    step(1, 1, 0);
    check("ss.busy", int'(bz_o[0]), 0);
    step(0, 0, 1);
    check("ss.ignored_bit", o_bit[0], 0);
    check("ss.ignored_busy", int'(bz_o[0]), 0);

    // five bytes: saturate vs wrap on 2-bit counters
    step(1, 0, 0);
    rises(45, 0);
    check("sat.byte_cnt", o_cnt[1], 3);
    check("wrap.byte_cnt", o_cnt[2], 1);
    check("w8.byte_cnt", o_cnt[0], 5);
    check("d4.byte_cnt_45", o_cnt[3], 9);

    // 4-bit data bytes
    step(0, 1, 0);
    step(1, 0, 0);
    rises(4, 0);
    check("d4.byte_done", int'(bd_o[3]), 1);
    check("d4.ack_slot", int'(as_o[3]), 1);
    step(0, 0, 1);
    check("d4.ack_done", int'(ad_o[3]), 1);
    check("d4.byte_cnt", o_cnt[3], 1);

    // bus timeout after TCYC idle cycles
    step(0, 1, 0);
    step(1, 0, 0);
    rises(3, 1);
    repeat (TCYC - 1) step(0, 0, 0);
    check("to.not_yet", int'(to_o[0]), 0);
    check("to.busy_before", int'(bz_o[0]), 1);
    step(0, 0, 0);
`ifdef I2C_SLAVE_FRAME_TIMEOUT_EN
    check("to.pulse", int'(to_o[0]), 1);
    check("to.busy_after", int'(bz_o[0]), 0);
    check("to.bit_idx", o_bit[0], 0);
`else
    check("to.pulse", int'(to_o[0]), 0);
    check("to.busy_after", int'(bz_o[0]), 1);
    check("to.bit_idx", o_bit[0], 3);
`endif
    step(0, 1, 0);

    // synchronous reset mid-frame
    step(1, 0, 0);
    rises(11, 0);
    check("pre.byte_cnt", o_cnt[0], 1);
    preset = 1;
    step(0, 0, 0);
    preset = 0;
    check("preset.byte_cnt", o_cnt[0], 0);
    check("preset.bit_idx", o_bit[0], 0);
    check("preset.busy", int'(bz_o[0]), 0);
    step(0, 0, 0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
